// File: rtl/result_scoreboard_pkg.sv
// Shared types and helpers for the result scoreboard: verdict state encoding,
// counter width and a saturating increment.
package result_scoreboard_pkg;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PASSED = 2'd1,
    ST_FAILED = 2'd2
  } sb_state_e;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic cnt_t satInc(input cnt_t value, input logic enable);
    if (enable && (value != {CNT_W{1'b1}})) begin
      return value + cnt_t'(1);
    end
    return value;
  endfunction

endpackage

// File: rtl/result_scoreboard_sync_fifo.sv
// Synchronous FIFO holding the expected-word queue. Pointers carry one extra
// wrap bit so that full and empty can be told apart.
module result_scoreboard_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] pushData_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] headData_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wrPtr_q;
  logic [AW:0]           rdPtr_q;
  logic                  doPush;
  logic                  doPop;

  assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o    = (wrPtr_q == rdPtr_q);
  assign doPush     = push_i && !full_o;
  assign doPop      = pop_i && !empty_o;
  assign headData_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + {{AW{1'b0}}, 1'b1};
      if (doPop)  rdPtr_q <= rdPtr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/result_scoreboard.sv
// In-order expected/measured comparator with saturating test and failure
// counters, a run timeout and sticky PASS/FAIL verdicts.
module result_scoreboard
  import result_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int NUM_TESTS      = 10,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  meas_valid,
  output logic                  meas_ready,
  input  logic [DATA_WIDTH-1:0] meas_data,
  input  logic                  all_done,
  output logic                  cmp_valid,
  output logic                  cmp_match,
  output logic [DATA_WIDTH-1:0] cmp_expected,
  output logic [DATA_WIDTH-1:0] cmp_measured,
  output logic [CNT_W-1:0]      test_count,
  output logic [CNT_W-1:0]      fail_count,
  output logic                  test_passed,
  output logic                  test_failed,
  output logic                  timed_out
);

  localparam bit   TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
  localparam cnt_t PASS_COUNT   = cnt_t'(NUM_TESTS);

  sb_state_e             state_q, state_d;
  cnt_t                  testCount_q, testCount_d;
  cnt_t                  failCount_q, failCount_d;
  cnt_t                  timer_q, timer_d;
  logic                  timedOut_q, timedOut_d;
  logic                  cmpValid_q;
  logic                  cmpMatch_q;
  logic [DATA_WIDTH-1:0] cmpExpected_q;
  logic [DATA_WIDTH-1:0] cmpMeasured_q;

  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [DATA_WIDTH-1:0] fifoHead;
  logic                  pushFire;
  logic                  popFire;
  logic                  headMatch;
  logic                  timeoutHit;

  result_scoreboard_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_expFifo (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .push_i    (pushFire),
    .pushData_i(exp_data),
    .pop_i     (popFire),
    .headData_o(fifoHead),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty)
  );

  assign exp_ready  = !fifoFull;
  assign meas_ready = (state_q == ST_RUN) && !fifoEmpty;
  assign pushFire   = exp_valid && exp_ready;
  assign popFire    = meas_valid && meas_ready;
  assign headMatch  = (fifoHead == meas_data);
  assign timeoutHit = TIMEOUT_EN && (timer_q == TIMEOUT_LAST);

  // The verdict looks at the next-state counts so a compare finishing in the
  // same cycle as all_done is included; a timeout overrides all_done.
  always_comb begin
    state_d     = state_q;
    timedOut_d  = timedOut_q;
    timer_d     = timer_q;
    testCount_d = satInc(testCount_q, popFire);
    failCount_d = satInc(failCount_q, popFire && !headMatch);
    if (state_q == ST_RUN) begin
      timer_d = satInc(timer_q, 1'b1);
      if (timeoutHit) begin
        state_d    = ST_FAILED;
        timedOut_d = 1'b1;
      end else if (all_done) begin
        if (failCount_d != '0) begin
          state_d = ST_FAILED;
        end else if (testCount_d == PASS_COUNT) begin
          state_d = ST_PASSED;
        end else begin
          state_d = ST_FAILED;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= ST_RUN;
      testCount_q   <= '0;
      failCount_q   <= '0;
      timer_q       <= '0;
      timedOut_q    <= 1'b0;
      cmpValid_q    <= 1'b0;
      cmpMatch_q    <= 1'b0;
      cmpExpected_q <= '0;
      cmpMeasured_q <= '0;
    end else begin
      state_q     <= state_d;
      testCount_q <= testCount_d;
      failCount_q <= failCount_d;
      timer_q     <= timer_d;
      timedOut_q  <= timedOut_d;
      cmpValid_q  <= popFire;
      if (popFire) begin
        cmpMatch_q    <= headMatch;
        cmpExpected_q <= fifoHead;
        cmpMeasured_q <= meas_data;
      end
    end
  end

  assign cmp_valid    = cmpValid_q;
  assign cmp_match    = cmpMatch_q;
  assign cmp_expected = cmpExpected_q;
  assign cmp_measured = cmpMeasured_q;
  assign test_count   = testCount_q;
  assign fail_count   = failCount_q;
  assign test_passed  = (state_q == ST_PASSED);
  assign test_failed  = (state_q == ST_FAILED);
  assign timed_out    = timedOut_q;

endmodule

// File: tb/tb_result_scoreboard.sv
// Bench for result_scoreboard: a table of hand-worked vectors, scripted
// scenarios and randomized traffic checked against a queue-based model.
module tb_result_scoreboard;

  localparam int DW        = 32;
  localparam int DEPTH     = 16;
  localparam int NUM_TESTS = 10;
  localparam int TIMEOUT   = 100;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          exp_valid = 1'b0;
  logic          exp_ready;
  logic [DW-1:0] exp_data = '0;
  logic          meas_valid = 1'b0;
  logic          meas_ready;
  logic [DW-1:0] meas_data = '0;
  logic          all_done = 1'b0;
  logic          cmp_valid;
  logic          cmp_match;
  logic [DW-1:0] cmp_expected;
  logic [DW-1:0] cmp_measured;
  logic [31:0]   test_count;
  logic [31:0]   fail_count;
  logic          test_passed;
  logic          test_failed;
  logic          timed_out;

  result_scoreboard #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .NUM_TESTS     (NUM_TESTS),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .exp_valid   (exp_valid),
    .exp_ready   (exp_ready),
    .exp_data    (exp_data),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_data   (meas_data),
    .all_done    (all_done),
    .cmp_valid   (cmp_valid),
    .cmp_match   (cmp_match),
    .cmp_expected(cmp_expected),
    .cmp_measured(cmp_measured),
    .test_count  (test_count),
    .fail_count  (fail_count),
    .test_passed (test_passed),
    .test_failed (test_failed),
    .timed_out   (timed_out)
  );

  always #5 ACLK = ~ACLK;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: a queue of expected words plus the verdict rules.
  logic [31:0] mQ[$];
  int          mTests, mFails, mCycles, mVerdict;
  bit          mTimedOut, mCmpValid, mCmpMatch;
  logic [31:0] mCmpExp, mCmpMeas;

  typedef struct {
    bit          ev;
    logic [31:0] ed;
    bit          mv;
    logic [31:0] md;
    bit          ad;
    bit          expRdy;
    bit          measRdy;
    bit          cv;
    bit          cm;
    int          tc;
    int          fc;
    bit          passed;
    bit          failed;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic modelReset();
    mQ.delete();
    mTests = 0; mFails = 0; mCycles = 0; mVerdict = 0;
    mTimedOut = 0; mCmpValid = 0; mCmpMatch = 0; mCmpExp = '0; mCmpMeas = '0;
  endtask

  // Called at posedge+1; asserts reset, checks the asynchronous clear, releases.
  task automatic doReset();
    exp_valid = 0; meas_valid = 0; all_done = 0; exp_data = '0; meas_data = '0;
    ARESETN = 0;
    #2;
    checkOutput("rst exp_ready", 32'(exp_ready), 32'd1);
    checkOutput("rst meas_ready", 32'(meas_ready), 32'd0);
    checkOutput("rst cmp_valid", 32'(cmp_valid), 32'd0);
    checkOutput("rst cmp_match", 32'(cmp_match), 32'd0);
    checkOutput("rst cmp_expected", cmp_expected, 32'd0);
    checkOutput("rst cmp_measured", cmp_measured, 32'd0);
    checkOutput("rst test_count", test_count, 32'd0);
    checkOutput("rst fail_count", fail_count, 32'd0);
    checkOutput("rst test_passed", 32'(test_passed), 32'd0);
    checkOutput("rst test_failed", 32'(test_failed), 32'd0);
    checkOutput("rst timed_out", 32'(timed_out), 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1;
    modelReset();
  endtask

  // One clock cycle of stimulus, checked against the model before and after the edge.
  task automatic applyStimulus(input bit ev, input logic [31:0] ed, input bit mv,
                               input logic [31:0] md, input bit ad);
    bit          expRdy, measRdy, pushOk, popOk;
    logic [31:0] head;
    exp_valid = ev; exp_data = ed; meas_valid = mv; meas_data = md; all_done = ad;
    expRdy  = (mQ.size() < DEPTH);
    measRdy = (mVerdict == 0) && (mQ.size() > 0);
    #1;
    checkOutput("exp_ready", 32'(exp_ready), 32'(expRdy));
    checkOutput("meas_ready", 32'(meas_ready), 32'(measRdy));
    pushOk = ev && expRdy;
    popOk  = mv && measRdy;
    mCmpValid = popOk;
    if (popOk) begin
      head = mQ.pop_front();
      mCmpExp = head; mCmpMeas = md; mCmpMatch = (head == md);
      mTests++;
      if (head != md) mFails++;
    end
    if (pushOk) mQ.push_back(ed);
    if (mVerdict == 0) begin
      if (TIMEOUT != 0 && mCycles == TIMEOUT - 1) begin
        mVerdict = 2; mTimedOut = 1;
      end else if (ad) begin
        if (mFails != 0) mVerdict = 2;
        else if (mTests == NUM_TESTS) mVerdict = 1;
        else mVerdict = 2;
      end
      mCycles++;
    end
    @(posedge ACLK); #1;
    checkOutput("cmp_valid", 32'(cmp_valid), 32'(mCmpValid));
    checkOutput("cmp_match", 32'(cmp_match), 32'(mCmpMatch));
    checkOutput("cmp_expected", cmp_expected, mCmpExp);
    checkOutput("cmp_measured", cmp_measured, mCmpMeas);
    checkOutput("test_count", test_count, 32'(mTests));
    checkOutput("fail_count", fail_count, 32'(mFails));
    checkOutput("test_passed", 32'(test_passed), 32'(mVerdict == 1));
    checkOutput("test_failed", 32'(test_failed), 32'(mVerdict == 2));
    checkOutput("timed_out", 32'(timed_out), 32'(mTimedOut));
    exp_valid = 0; meas_valid = 0; all_done = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] md;
    // Empty-FIFO stall, late push, a mismatch, verdict and terminal behaviour.
    vecs[0] = '{0, 32'h0,  1, 32'h55, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 32'h55, 1, 32'h55, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 32'h0,  1, 32'h55, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    vecs[3] = '{0, 32'h0,  1, 32'h66, 0, 1, 0, 0, 1, 1, 0, 0, 0};
    vecs[4] = '{1, 32'h10, 0, 32'h0,  0, 1, 0, 0, 1, 1, 0, 0, 0};
    vecs[5] = '{0, 32'h0,  1, 32'h11, 0, 1, 1, 1, 0, 2, 1, 0, 0};
    vecs[6] = '{0, 32'h0,  0, 32'h0,  1, 1, 0, 0, 0, 2, 1, 0, 1};
    vecs[7] = '{1, 32'h20, 0, 32'h0,  1, 1, 0, 0, 0, 2, 1, 0, 1};
    vecs[8] = '{0, 32'h0,  1, 32'h20, 0, 1, 0, 0, 0, 2, 1, 0, 1};

    @(posedge ACLK); #1;
    doReset();
    for (int i = 0; i < 9; i++) begin
      exp_valid = vecs[i].ev; exp_data = vecs[i].ed; meas_valid = vecs[i].mv;
      meas_data = vecs[i].md; all_done = vecs[i].ad;
      #1;
      checkOutput($sformatf("vec%0d exp_ready", i), 32'(exp_ready), 32'(vecs[i].expRdy));
      checkOutput($sformatf("vec%0d meas_ready", i), 32'(meas_ready), 32'(vecs[i].measRdy));
      @(posedge ACLK); #1;
      checkOutput($sformatf("vec%0d cmp_valid", i), 32'(cmp_valid), 32'(vecs[i].cv));
      checkOutput($sformatf("vec%0d cmp_match", i), 32'(cmp_match), 32'(vecs[i].cm));
      checkOutput($sformatf("vec%0d test_count", i), test_count, 32'(vecs[i].tc));
      checkOutput($sformatf("vec%0d fail_count", i), fail_count, 32'(vecs[i].fc));
      checkOutput($sformatf("vec%0d test_passed", i), 32'(test_passed), 32'(vecs[i].passed));
      checkOutput($sformatf("vec%0d test_failed", i), 32'(test_failed), 32'(vecs[i].failed));
    end

    // Ten matching compares then all_done: PASS.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'(i), 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 32'(i), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1 test_count", test_count, 32'd10);
    checkOutput("t1 test_passed", 32'(test_passed), 32'd1);

    // Word 3 corrupted: mismatch pulse right after that handshake, then FAIL.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1, 32'(i), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, (i == 3) ? 32'hDEADBEEF : 32'(i), 0);
      if (i == 3) begin
        checkOutput("t2 cmp_valid", 32'(cmp_valid), 32'd1);
        checkOutput("t2 cmp_match", 32'(cmp_match), 32'd0);
        checkOutput("t2 cmp_measured", cmp_measured, 32'hDEADBEEF);
      end
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t2 fail_count", fail_count, 32'd1);
    checkOutput("t2 test_failed", 32'(test_failed), 32'd1);

    // Fill to full, dropped push, pop at full, simultaneous push/pop, drain in order.
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1, 32'h100 + 32'(i), 0, 0, 0);
    checkOutput("t3 full exp_ready", 32'(exp_ready), 32'd0);
    applyStimulus(1, 32'hBAD, 0, 0, 0);
    applyStimulus(1, 32'h200, 1, 32'h100, 0);
    applyStimulus(1, 32'h201, 1, 32'h101, 0);
    applyStimulus(1, 32'h202, 0, 0, 0);
    checkOutput("t3 refull exp_ready", 32'(exp_ready), 32'd0);
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 0, 1, (i < 14) ? 32'h102 + 32'(i) : 32'h201 + 32'(i - 14), 0);
    checkOutput("t3 test_count", test_count, 32'd18);
    checkOutput("t3 fail_count", fail_count, 32'd0);
    checkOutput("t3 drained meas_ready", 32'(meas_ready), 32'd0);

    // Timeout after 100 cycles in RUN; later all_done ignored.
    doReset();
    for (int i = 0; i < 99; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5 before timeout", 32'(test_failed), 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t5 test_failed", 32'(test_failed), 32'd1);
    checkOutput("t5 timed_out", 32'(timed_out), 32'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5 no pass", 32'(test_passed), 32'd0);

    // Nine compares is the wrong count; then a reset dropped mid-run.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1, 32'h30 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 32'h30 + 32'(i), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6 test_failed", 32'(test_failed), 32'd1);
    checkOutput("t6 timed_out", 32'(timed_out), 32'd0);
    doReset();
    applyStimulus(1, 32'h77, 0, 0, 0);
    applyStimulus(1, 32'h78, 1, 32'h77, 0);
    doReset();

    // Randomized traffic against the model.
    for (int ep = 0; ep < 6; ep++) begin
      doReset();
      for (int c = 0; c < 60 + int'($urandom_range(0, 60)); c++) begin
        if (mQ.size() > 0 && $urandom_range(0, 9) < 8) md = mQ[0];
        else md = $urandom;
        applyStimulus($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
                      md, $urandom_range(0, 99) < 3);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
